// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//
// Program counter and instruction fetch. The PC is updated from one of four
// sources under an unconditional or an ALU-zero-conditional strobe. An
// instruction fetch is a single-outstanding read with an ack timeout. A
// timeout locks the unit in an error state until reset.
//
// Ports
//   clk_i            clock, rising edge
//   reset_i          synchronous active-low reset
//   pc_write_i       unconditional PC update strobe
//   pc_write_cond_i  PC update strobe, qualified by alu_zero_i
//   pc_src_i         00 pc+1, 01 alu_result, 10 {pc[hi:8],imm}, 11 ra
//   alu_zero_i       branch condition
//   alu_result_i     branch target
//   ra_i             return address
//   write_ir_i       fetch command
//   done_i           halt; blocks new fetches
//   mem_req_o        read request, high while in REQ
//   mem_addr_o       address latched at fetch start
//   mem_rdata_i      instruction word, valid with mem_ack_i
//   mem_ack_i        single-cycle read completion
//   op_o / imm_o     ir[15:8] / ir[7:0]
//   pc_o             current PC
//   ir_valid_o       IR holds the instruction for the current PC
//   fetch_busy_o     fetch outstanding
//   fetch_err_o      sticky timeout flag
//   instr_count_o    saturating count of instructions loaded
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no fetch outstanding; a fetch starts on write_ir
// REQ   | read outstanding; waiting for mem_ack or timeout
// ERR   | ack timed out; no further fetches until reset

module pc_fetch_unit #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              pc_write_i,
   input  logic              pc_write_cond_i,
   input  logic [1:0]        pc_src_i,
   input  logic              alu_zero_i,
   input  logic [ADDR_W-1:0] alu_result_i,
   input  logic [ADDR_W-1:0] ra_i,
   input  logic              write_ir_i,
   input  logic              done_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic [7:0]        op_o,
   output logic [7:0]        imm_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              ir_valid_o,
   output logic              fetch_busy_o,
   output logic              fetch_err_o,
   output logic [15:0]       instr_count_o
);

   localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_ERR  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic                ir_valid_q, ir_valid_d;
   logic [15:0]         count_q, count_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;

   logic                fetch_start;
   logic                fetch_done;
   logic                wait_expired;
   logic                pc_update;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (fetch_start) state_d = S_REQ;
         S_REQ: begin
            if (fetch_done) begin
               state_d = S_IDLE;
            end else if (wait_expired) begin
               state_d = S_ERR;
            end
         end
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs and fetch strobes
   // ---------------------------------------------------------------------
   always_comb begin
      mem_req_o    = 1'b0;
      fetch_busy_o = 1'b0;
      fetch_err_o  = 1'b0;
      fetch_start  = 1'b0;
      fetch_done   = 1'b0;
      case (state_q)
         S_IDLE: fetch_start = write_ir_i & ~done_i & ~ir_valid_q;
         S_REQ: begin
            mem_req_o    = 1'b1;
            fetch_busy_o = 1'b1;
            fetch_done   = mem_ack_i;
         end
         S_ERR:   fetch_err_o = 1'b1;
         default: ;
      endcase
   end

   // This edge would be the TIMEOUT-th cycle spent waiting.
   assign wait_expired = (wait_q == WAIT_W'(TIMEOUT - 1));

   // ---------------------------------------------------------------------
   // Datapath next-state
   // ---------------------------------------------------------------------
   assign pc_update = pc_write_i | (pc_write_cond_i & alu_zero_i);

   always_comb begin
      pc_d       = pc_q;
      addr_d     = addr_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      count_d    = count_q;
      wait_d     = wait_q;

      if (pc_update) begin
         case (pc_src_i)
            2'b00:   pc_d = pc_q + ADDR_W'(1);
            2'b01:   pc_d = alu_result_i;
            2'b10:   pc_d = {pc_q[ADDR_W-1:8], ir_q[7:0]};
            default: pc_d = ra_i;
         endcase
      end

      if (fetch_start) begin
         addr_d = pc_q;
         wait_d = '0;
      end

      if (fetch_done) begin
         ir_d       = mem_rdata_i;
         ir_valid_d = 1'b1;
         wait_d     = '0;
         if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
         end
      end else if (state_q == S_REQ) begin
         wait_d = wait_q + WAIT_W'(1);
      end

      // A PC change invalidates the IR even when a fetch lands on the same edge.
      if (pc_update) begin
         ir_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         pc_q       <= '0;
         addr_q     <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         count_q    <= '0;
         wait_q     <= '0;
      end else begin
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         count_q    <= count_d;
         wait_q     <= wait_d;
      end
   end

   assign mem_addr_o    = addr_q;
   assign op_o          = ir_q[15:8];
   assign imm_o         = ir_q[7:0];
   assign pc_o          = pc_q;
   assign ir_valid_o    = ir_valid_q;
   assign instr_count_o = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        pc_write_i, pc_write_cond_i, alu_zero_i;
   logic [1:0]  pc_src_i;
   logic [15:0] alu_result_i, ra_i;
   logic        write_ir_i, done_i;
   logic        mem_req_o;
   logic [15:0] mem_addr_o;
   logic [15:0] mem_rdata_i;
   logic        mem_ack_i;
   logic [7:0]  op_o, imm_o;
   logic [15:0] pc_o;
   logic        ir_valid_o, fetch_busy_o, fetch_err_o;
   logic [15:0] instr_count_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   pc_fetch_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(255)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .pc_write_i(pc_write_i), .pc_write_cond_i(pc_write_cond_i),
      .pc_src_i(pc_src_i), .alu_zero_i(alu_zero_i),
      .alu_result_i(alu_result_i), .ra_i(ra_i),
      .write_ir_i(write_ir_i), .done_i(done_i),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
      .op_o(op_o), .imm_o(imm_o), .pc_o(pc_o),
      .ir_valid_o(ir_valid_o), .fetch_busy_o(fetch_busy_o),
      .fetch_err_o(fetch_err_o), .instr_count_o(instr_count_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      pc_write_i = 0; pc_write_cond_i = 0; pc_src_i = 2'b00; alu_zero_i = 0;
      alu_result_i = 16'h0; ra_i = 16'h0; write_ir_i = 0; done_i = 0;
      mem_rdata_i = 16'h0; mem_ack_i = 0;
   endtask

   task automatic set_pc(input logic [15:0] v);
      pc_write_i = 1; pc_src_i = 2'b01; alu_result_i = v;
      tick();
      pc_write_i = 0; pc_src_i = 2'b00;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_i = 0;
      tick(); tick();
      reset_i = 1;
      checks++;
      if ({pc_o, op_o, imm_o, ir_valid_o, mem_req_o, mem_addr_o, fetch_busy_o, fetch_err_o, instr_count_o}
          !== {16'h0, 8'h0, 8'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0}) begin
         errors++;
         $display("FAIL reset_state: pc=%h op=%h imm=%h v=%b req=%b addr=%h busy=%b err=%b cnt=%h, required all zero",
                  pc_o, op_o, imm_o, ir_valid_o, mem_req_o, mem_addr_o, fetch_busy_o, fetch_err_o, instr_count_o);
      end
   endtask

   task automatic test_basic_fetch();
      write_ir_i = 1;
      tick();
      write_ir_i = 0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({mem_req_o, fetch_busy_o, mem_addr_o} !== {1'b1, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL fetch_wait[%0d]: req=%b busy=%b addr=%h, required 1 1 0000", i, mem_req_o, fetch_busy_o, mem_addr_o);
         end
         tick();
      end
      mem_ack_i = 1; mem_rdata_i = 16'h1005;
      checks++;
      if (mem_addr_o !== 16'h0000) begin
         errors++;
         $display("FAIL fetch_addr_at_ack: addr=%h, required 0000", mem_addr_o);
      end
      tick();
      mem_ack_i = 0; mem_rdata_i = 16'h0;
      checks++;
      if ({op_o, imm_o, ir_valid_o, instr_count_o, mem_req_o, fetch_busy_o}
          !== {8'h10, 8'h05, 1'b1, 16'd1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL fetch_result: op=%h imm=%h v=%b cnt=%0d req=%b busy=%b, required 10 05 1 1 0 0",
                  op_o, imm_o, ir_valid_o, instr_count_o, mem_req_o, fetch_busy_o);
      end
      // IR already valid: a fetch command must not issue a request
      write_ir_i = 1;
      tick();
      write_ir_i = 0;
      checks++;
      if ({mem_req_o, ir_valid_o} !== 2'b01) begin
         errors++;
         $display("FAIL refetch_blocked: req=%b v=%b, required 0 1", mem_req_o, ir_valid_o);
      end
   endtask

   task automatic test_branch_cond();
      pc_write_cond_i = 1; pc_src_i = 2'b01; alu_result_i = 16'h0040; alu_zero_i = 0;
      tick();
      checks++;
      if ({pc_o, ir_valid_o} !== {16'h0000, 1'b1}) begin
         errors++;
         $display("FAIL cond_not_taken: pc=%h v=%b, required 0000 1", pc_o, ir_valid_o);
      end
      alu_zero_i = 1;
      tick();
      pc_write_cond_i = 0; alu_zero_i = 0;
      checks++;
      if ({pc_o, ir_valid_o} !== {16'h0040, 1'b0}) begin
         errors++;
         $display("FAIL cond_taken: pc=%h v=%b, required 0040 0", pc_o, ir_valid_o);
      end
   endtask

   task automatic test_pc_wrap_and_imm();
      set_pc(16'hFFFF);
      pc_write_i = 1; pc_src_i = 2'b00;
      tick();
      pc_write_i = 0;
      checks++;
      if (pc_o !== 16'h0000) begin
         errors++;
         $display("FAIL pc_wrap: pc=%h, required 0000", pc_o);
      end
      set_pc(16'h1234);
      write_ir_i = 1;
      tick();
      write_ir_i = 0;
      mem_ack_i = 1; mem_rdata_i = 16'h2256;
      checks++;
      if (mem_addr_o !== 16'h1234) begin
         errors++;
         $display("FAIL imm_fetch_addr: addr=%h, required 1234", mem_addr_o);
      end
      tick();
      mem_ack_i = 0;
      pc_write_i = 1; pc_src_i = 2'b10;
      tick();
      pc_write_i = 0; pc_src_i = 2'b00;
      checks++;
      if ({pc_o, instr_count_o} !== {16'h1256, 16'd2}) begin
         errors++;
         $display("FAIL pc_imm: pc=%h cnt=%0d, required 1256 2", pc_o, instr_count_o);
      end
   endtask

   task automatic test_ack_with_pc_update();
      set_pc(16'h0100);
      write_ir_i = 1;
      tick();
      write_ir_i = 0;
      pc_write_i = 1; pc_src_i = 2'b00;
      tick();
      pc_write_i = 0;
      checks++;
      if ({pc_o, mem_addr_o, mem_req_o} !== {16'h0101, 16'h0100, 1'b1}) begin
         errors++;
         $display("FAIL addr_stable: pc=%h addr=%h req=%b, required 0101 0100 1", pc_o, mem_addr_o, mem_req_o);
      end
      pc_write_i = 1; pc_src_i = 2'b11; ra_i = 16'h0200;
      mem_ack_i = 1; mem_rdata_i = 16'hABCD;
      tick();
      pc_write_i = 0; pc_src_i = 2'b00; mem_ack_i = 0;
      checks++;
      if ({op_o, imm_o, ir_valid_o, pc_o, instr_count_o, mem_req_o}
          !== {8'hAB, 8'hCD, 1'b0, 16'h0200, 16'd3, 1'b0}) begin
         errors++;
         $display("FAIL ack_pc_collide: op=%h imm=%h v=%b pc=%h cnt=%0d req=%b, required AB CD 0 0200 3 0",
                  op_o, imm_o, ir_valid_o, pc_o, instr_count_o, mem_req_o);
      end
   endtask

   task automatic test_done_and_stray_ack();
      done_i = 1; write_ir_i = 1;
      tick(); tick();
      write_ir_i = 0;
      checks++;
      if (mem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL done_blocks: req=%b, required 0", mem_req_o);
      end
      done_i = 0;
      mem_ack_i = 1; mem_rdata_i = 16'h5A5A;
      tick();
      mem_ack_i = 0;
      checks++;
      if ({op_o, ir_valid_o, instr_count_o} !== {8'hAB, 1'b0, 16'd3}) begin
         errors++;
         $display("FAIL stray_ack: op=%h v=%b cnt=%0d, required AB 0 3", op_o, ir_valid_o, instr_count_o);
      end
      // done raised while a fetch is outstanding: fetch still completes
      write_ir_i = 1;
      tick();
      write_ir_i = 0; done_i = 1;
      mem_ack_i = 1; mem_rdata_i = 16'h3344;
      tick();
      mem_ack_i = 0; done_i = 0;
      checks++;
      if ({op_o, imm_o, ir_valid_o, instr_count_o} !== {8'h33, 8'h44, 1'b1, 16'd4}) begin
         errors++;
         $display("FAIL done_midfetch: op=%h imm=%h v=%b cnt=%0d, required 33 44 1 4", op_o, imm_o, ir_valid_o, instr_count_o);
      end
   endtask

   task automatic test_reset_mid_fetch();
      set_pc(16'h0300);
      write_ir_i = 1;
      tick();
      write_ir_i = 0;
      reset_i = 0;
      tick();
      reset_i = 1;
      mem_ack_i = 1; mem_rdata_i = 16'h7777;
      tick();
      mem_ack_i = 0;
      checks++;
      if ({pc_o, op_o, imm_o, ir_valid_o, mem_req_o, mem_addr_o, fetch_busy_o, fetch_err_o, instr_count_o}
          !== {16'h0, 8'h0, 8'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0}) begin
         errors++;
         $display("FAIL reset_midfetch: pc=%h op=%h imm=%h v=%b req=%b addr=%h busy=%b err=%b cnt=%h, required all zero",
                  pc_o, op_o, imm_o, ir_valid_o, mem_req_o, mem_addr_o, fetch_busy_o, fetch_err_o, instr_count_o);
      end
   endtask

   task automatic test_timeout();
      int high_cycles;
      high_cycles = 0;
      write_ir_i = 1;
      tick();
      write_ir_i = 0;
      for (int i = 0; i < 300 && mem_req_o; i++) begin
         high_cycles++;
         tick();
      end
      checks++;
      if ({high_cycles, mem_req_o, fetch_err_o, fetch_busy_o} !== {32'd255, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL timeout: req_cycles=%0d req=%b err=%b busy=%b, required 255 0 1 0",
                  high_cycles, mem_req_o, fetch_err_o, fetch_busy_o);
      end
      write_ir_i = 1;
      tick(); tick(); tick();
      write_ir_i = 0;
      checks++;
      if ({mem_req_o, fetch_err_o} !== 2'b01) begin
         errors++;
         $display("FAIL err_terminal: req=%b err=%b, required 0 1", mem_req_o, fetch_err_o);
      end
      reset_i = 0;
      tick();
      reset_i = 1;
      checks++;
      if (fetch_err_o !== 1'b0) begin
         errors++;
         $display("FAIL err_reset: err=%b, required 0", fetch_err_o);
      end
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_branch_cond();
      test_pc_wrap_and_imm();
      test_ack_with_pc_update();
      test_done_and_stray_ack();
      test_reset_mid_fetch();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 16: program counter and memory address width.
REQ-002 Parameter DATA_W, default 16: instruction word width; op = word[15:8], imm = word[7:0].
REQ-003 Parameter TIMEOUT, default 255: maximum number of cycles waited for mem_ack.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 pc_write  in  1  unconditional PC update strobe from control.
REQ-007 pc_write_cond  in  1  conditional PC update strobe; takes effect only when alu_zero=1.
REQ-008 pc_src  in  2  PC next-value select: 00 pc+1, 01 alu_result, 10 {pc[ADDR_W-1:8],imm}, 11 ra.
REQ-009 alu_zero  in  1  branch condition from the ALU.
REQ-010 alu_result  in  ADDR_W  branch target.
REQ-011 ra  in  ADDR_W  return-address register value.
REQ-012 write_ir  in  1  fetch command from control.
REQ-013 done  in  1  halt indication from control.
REQ-014 mem_req  out  1  instruction read request.
REQ-015 mem_addr  out  ADDR_W  latched fetch address.
REQ-016 mem_rdata  in  DATA_W  instruction data; valid only when mem_ack=1.
REQ-017 mem_ack  in  1  single-cycle read completion.
REQ-018 op  out  8  opcode to control, taken from ir[15:8].
REQ-019 imm  out  8  ir[7:0].
REQ-020 pc  out  ADDR_W  current PC.
REQ-021 ir_valid  out  1  IR holds the instruction fetched from the current pc.
REQ-022 fetch_busy  out  1  high while a fetch is outstanding.
REQ-023 fetch_err  out  1  sticky timeout flag.
REQ-024 instr_count  out  16  count of instructions loaded.

Function
REQ-025 PC update: pc SHALL take the value selected by pc_src when (pc_write | (pc_write_cond & alu_zero)) is high. Otherwise pc SHALL hold.
REQ-026 The pc+1 arithmetic SHALL wrap modulo 2^ADDR_W; all-ones + 1 = 0.
REQ-027 The FSM SHALL have the states IDLE, REQ and ERR.
REQ-028 IDLE->REQ: when write_ir=1, done=0 and ir_valid=0. On entry, mem_addr SHALL latch pc and mem_req SHALL go high in the next cycle.
REQ-029 REQ with mem_ack=1: ir<=mem_rdata, ir_valid<=1, instr_count++, and the FSM SHALL return to IDLE. The IR SHALL be visible on op and imm one cycle after the ack.
REQ-030 REQ with mem_ack=0: the wait counter SHALL increment. When it reaches TIMEOUT, the FSM SHALL go to ERR, mem_req SHALL drop and fetch_err SHALL be set.
REQ-031 ERR SHALL be terminal until reset: no requests are issued and fetch_err stays 1.
REQ-032 mem_req=fetch_busy=1 exactly while the FSM is in REQ.
REQ-033 mem_addr SHALL be stable throughout REQ, even if pc changes mid-fetch.
REQ-034 Any PC update (REQ-025) SHALL clear ir_valid in the same edge. If that edge coincides with the mem_ack of an outstanding fetch, ir_valid SHALL end at 0 while ir still loads.
REQ-035 write_ir while in REQ or ERR SHALL be ignored. write_ir while ir_valid=1 SHALL be ignored and no re-fetch is issued.
REQ-036 done=1 SHALL block new fetches. A fetch already outstanding SHALL complete normally.
REQ-037 instr_count SHALL saturate at 0xFFFF.
REQ-038 mem_ack received outside REQ SHALL be ignored.

Reset
REQ-039 When reset=0 at a clock edge, the block SHALL set: pc=0, ir=0 (so op=0, imm=0), ir_valid=0, mem_req=0, mem_addr=0, fetch_busy=0, fetch_err=0, instr_count=0, wait counter=0, FSM=IDLE.
REQ-040 A reset asserted mid-fetch SHALL abandon the fetch; a late mem_ack after reset has no effect.

Verification
REQ-041 pc=0x0000, write_ir pulse, mem_ack with rdata=0x1005 after 3 cycles -> op=0x10, imm=0x05, ir_valid=1, instr_count=1, mem_addr=0x0000 throughout.
REQ-042 pc_write_cond=1, pc_src=01, alu_result=0x0040: with alu_zero=0 -> pc unchanged; with alu_zero=1 -> pc=0x0040 and ir_valid=0.
REQ-043 pc=0xFFFF, pc_write=1, pc_src=00 -> pc=0x0000. Separately, pc_src=10 with pc=0x1234, imm=0x56 -> pc=0x1256.
REQ-044 write_ir, then mem_ack never arrives -> after 255 wait cycles mem_req=0, fetch_err=1; further write_ir produces no mem_req.
REQ-045 Fetch outstanding, pc_write=1 pc_src=11 ra=0x0200 on the same edge as mem_ack -> ir loaded, ir_valid=0, pc=0x0200.
REQ-046 Fetch outstanding, reset=0 for one cycle, then mem_ack -> all outputs at reset values, ir=0, instr_count=0.
